photon_pulse_counter: RTL



---
 rtl/photon_pulse_counter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/photon_pulse_counter.sv
// photon_pulse_counter
// Front-end counting stage of the single-photon counter. Synchronises the
// asynchronous photon pulse, counts its rising edges per fixed gate window,
// and keeps a small circular history of completed window counts.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   counting enable (level); low forces timer/cnt_now to 0
//   clr        in   synchronous single-cycle clear of counters and history fill
//   ex_pulse   in   external photon pulse, asynchronous
//   cnt_now    out  live count of the current window (saturating)
//   cnt_last   out  count of the last completed window
//   cnt_valid  out  one-cycle strobe: cnt_last/history just updated
//   total      out  edges counted since reset/clr (saturating)
//   overflow   out  sticky: a window count or the total saturated
//   hist_raddr in   history read address
//   hist_rdata out  history data, one cycle after the address
//   hist_wptr  out  index of the most recent history entry
//   hist_fill  out  number of valid history entries, 0..DEPTH
module photon_pulse_counter #(
  parameter int GATE_CYCLES = 80_000_000,
  parameter int CNT_W       = 24,
  parameter int TOT_W       = 32,
  parameter int DEPTH       = 64,
  parameter int AW          = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             ex_pulse,
  output logic [CNT_W-1:0] cnt_now,
  output logic [CNT_W-1:0] cnt_last,
  output logic             cnt_valid,
  output logic [TOT_W-1:0] total,
  output logic             overflow,
  input  logic [AW-1:0]    hist_raddr,
  output logic [CNT_W-1:0] hist_rdata,
  output logic [AW-1:0]    hist_wptr,
  output logic [AW:0]      hist_fill
);

  localparam int TMR_W = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [TOT_W-1:0] TOT_MAX   = '1;
  localparam logic [AW:0]      FILL_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    WPTR_RST  = AW'(DEPTH - 1);

  logic [TMR_W-1:0] timer;
  logic             sync1, sync2, sync3;
  logic             edge_q;
  logic             term;
  logic [CNT_W-1:0] cnt_next;
  logic [AW-1:0]    wptr_next;

  // History storage is intentionally not reset; hist_fill tells consumers
  // which entries are meaningful.
  logic [CNT_W-1:0] mem [DEPTH];

  // Terminal cycle of the gate window; only meaningful while counting.
  assign term      = en && (timer == TMR_LAST);
  assign wptr_next = hist_wptr + AW'(1);

  // Window count including this cycle's edge, held at full scale. On the
  // terminal cycle this is the closing window's final value.
  always_comb begin
    cnt_next = cnt_now;
    if (edge_q && (cnt_now != CNT_MAX)) cnt_next = cnt_now + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (term && !clr) mem[wptr_next] <= cnt_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      edge_q     <= 1'b0;
      timer      <= '0;
      cnt_now    <= '0;
      cnt_last   <= '0;
      cnt_valid  <= 1'b0;
      total      <= '0;
      overflow   <= 1'b0;
      hist_rdata <= '0;
      hist_wptr  <= WPTR_RST;
      hist_fill  <= '0;
    end else begin
      // Two-flop synchroniser, then a registered rising-edge detect so the
      // count lands three cycles after the pulse is first sampled.
      sync1  <= ex_pulse;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= sync2 & ~sync3;

      // Read-first: a same-cycle write to this address shows up next read.
      hist_rdata <= mem[hist_raddr];

      cnt_valid <= 1'b0;

      if (clr) begin
        timer     <= '0;
        cnt_now   <= '0;
        cnt_last  <= '0;
        total     <= '0;
        overflow  <= 1'b0;
        hist_fill <= '0;
        hist_wptr <= WPTR_RST;
      end else if (!en) begin
        timer   <= '0;
        cnt_now <= '0;
      end else begin
        if (edge_q) begin
          if ((cnt_now == CNT_MAX) || (total == TOT_MAX)) overflow <= 1'b1;
          if (total != TOT_MAX) total <= total + TOT_W'(1);
        end
        if (term) begin
          timer     <= '0;
          cnt_now   <= '0;
          cnt_last  <= cnt_next;
          hist_wptr <= wptr_next;
          if (hist_fill != FILL_MAX) hist_fill <= hist_fill + (AW+1)'(1);
          cnt_valid <= 1'b1;
        end else begin
          timer   <= timer + TMR_W'(1);
          cnt_now <= cnt_next;
        end
      end
    end
  end

endmodule
